motor_fault_handler: RTL and testbench

Sequential consumer of the combinational `fault` flag from the fault-detection logic. It qualifies the flag, removes drive enable on a trip, enforces a cooldown, and auto-restarts a bounded number of times before latching a lockout that needs an explicit clear. It sits between fault detection and the PWM/commutation stage, which gates its outputs with `drive_enable`.

---
 rtl/motor_fault_handler.sv | 66 ++++++
 tb/tb_motor_fault_handler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/motor_fault_handler.sv
// motor_fault_handler: qualifies fault, trips drive, cools down, auto-restarts, then latches lockout
module motor_fault_handler #(
  parameter int QUAL_CYCLES     = 2,
  parameter int COOLDOWN_CYCLES = 1000,
  parameter int MAX_RETRIES     = 3,
  parameter int CNT_W           = 16,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fault,
  input  logic          enable_req,
  input  logic          fault_clear,
  output logic          drive_enable,
  output logic          fault_latched,
  output logic          lockout,
  output logic [RW-1:0] retry_count
);
  localparam int QW = $clog2(QUAL_CYCLES + 1);
  localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, HOLD = 3'd2, COOL = 3'd3, LOCK = 3'd4;
  localparam logic [QW-1:0] QUAL_LAST = QW'(QUAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
  logic [2:0]       state;
  logic [QW-1:0]    qual;
  logic [CNT_W-1:0] cnt;
  assign drive_enable  = state == RUN;
  assign fault_latched = state == HOLD || state == COOL || state == LOCK;
  assign lockout       = state == LOCK;
  // state machine with qualification, cooldown and retry bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      qual        <= '0;
      cnt         <= '0;
      retry_count <= '0;
    end else begin
      qual <= (state == RUN && fault && qual != QUAL_LAST) ? qual + 1'b1 : '0;
      case (state)
        IDLE: begin
          if (!enable_req) retry_count <= '0;
          if (enable_req && !fault) state <= RUN;
        end
        RUN: state <= (fault && qual == QUAL_LAST) ? HOLD : (!enable_req ? IDLE : RUN);
        HOLD: if (!fault) begin
          if (retry_count == RETRY_MAX) state <= LOCK;
          else begin
            retry_count <= retry_count + 1'b1;
            cnt         <= COOL_LOAD;
            state       <= COOL;
          end
        end
        COOL: begin
          if (fault) state <= HOLD;
          else if (cnt == '0) state <= enable_req ? RUN : IDLE;
          else cnt <= cnt - 1'b1;
        end
        LOCK: if (fault_clear && !fault) begin
          state       <= IDLE;
          retry_count <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_motor_fault_handler.sv
// tb_motor_fault_handler: directed scenarios plus randomized run against a behavioural model
module tb_motor_fault_handler;
  localparam int QUAL = 2, COOL = 4, MAXR = 3;
  logic clk = 0, rst = 0, fault = 0, enable_req = 0, fault_clear = 0;
  logic drive_enable, fault_latched, lockout;
  logic [1:0] retry_count;
  logic [4:0] obs;
  int n_cmp = 0, n_bad = 0;
  typedef enum {M_IDLE, M_RUN, M_HOLD, M_COOL, M_LOCK} mode_t;
  mode_t m_mode = M_IDLE;
  int m_streak = 0, m_left = 0, m_retries = 0;

  motor_fault_handler #(.QUAL_CYCLES(QUAL), .COOLDOWN_CYCLES(COOL), .MAX_RETRIES(MAXR), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .fault(fault), .enable_req(enable_req), .fault_clear(fault_clear),
    .drive_enable(drive_enable), .fault_latched(fault_latched), .lockout(lockout), .retry_count(retry_count));

  always #5 clk = ~clk;
  assign obs = {drive_enable, fault_latched, lockout, retry_count};

  function automatic logic [4:0] model_out();
    return {m_mode == M_RUN, m_mode == M_HOLD || m_mode == M_COOL || m_mode == M_LOCK,
            m_mode == M_LOCK, 2'(m_retries)};
  endfunction

  task automatic tick(input logic r, input logic f, input logic e, input logic c);
    rst = r; fault = f; enable_req = e; fault_clear = c;
    @(posedge clk);
    if (m_mode != M_RUN) m_streak = 0;
    if (r) begin
      m_mode = M_IDLE; m_streak = 0; m_left = 0; m_retries = 0;
    end else case (m_mode)
      M_IDLE: begin
        if (!e) m_retries = 0;
        if (e && !f) m_mode = M_RUN;
      end
      M_RUN: begin
        m_streak = f ? m_streak + 1 : 0;
        if (m_streak == QUAL) m_mode = M_HOLD;
        else if (!e) m_mode = M_IDLE;
      end
      M_HOLD: if (!f) begin
        if (m_retries == MAXR) m_mode = M_LOCK;
        else begin m_retries++; m_left = COOL; m_mode = M_COOL; end
      end
      M_COOL: begin
        if (f) m_mode = M_HOLD;
        else begin
          m_left--;
          if (m_left == 0) m_mode = e ? M_RUN : M_IDLE;
        end
      end
      M_LOCK: if (c && !f) begin m_mode = M_IDLE; m_retries = 0; end
    endcase
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0);
    n_cmp++; if (obs !== 5'b00000) begin n_bad++; $display("FAIL reset: got %b want 00000", obs); end
    tick(0, 0, 0, 0);
    n_cmp++; if (obs !== 5'b00000) begin n_bad++; $display("FAIL reset_idle: got %b want 00000", obs); end
  endtask

  task automatic test_start();
    tick(0, 0, 1, 0);
    n_cmp++; if (obs !== 5'b10000) begin n_bad++; $display("FAIL start: got %b want 10000", obs); end
  endtask

  task automatic test_glitch();
    tick(0, 1, 1, 0);
    n_cmp++; if (obs !== 5'b10000) begin n_bad++; $display("FAIL glitch_hi: got %b want 10000", obs); end
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 1, 0);
      n_cmp++; if (obs !== 5'b10000) begin n_bad++; $display("FAIL glitch_lo%0d: got %b want 10000", i, obs); end
    end
  endtask

  task automatic test_single_trip();
    tick(0, 1, 1, 0);
    n_cmp++; if (obs !== 5'b10000) begin n_bad++; $display("FAIL trip_edge1: got %b want 10000", obs); end
    for (int i = 0; i < 2; i++) begin
      tick(0, 1, 1, 0);
      n_cmp++; if (obs !== 5'b01000) begin n_bad++; $display("FAIL trip_hold%0d: got %b want 01000", i, obs); end
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 1, 0);
      n_cmp++; if (obs !== 5'b01001) begin n_bad++; $display("FAIL trip_cool%0d: got %b want 01001", i, obs); end
    end
    tick(0, 0, 1, 0);
    n_cmp++; if (obs !== 5'b10001) begin n_bad++; $display("FAIL trip_restart: got %b want 10001", obs); end
  endtask

  task automatic test_lockout();
    tick(1, 0, 0, 0);
    tick(0, 0, 1, 0);
    for (int t = 1; t <= 4; t++) begin
      tick(0, 1, 1, 0); tick(0, 1, 1, 0); tick(0, 0, 1, 0);
      if (t < 4) begin
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 0);
        n_cmp++;
        if (obs !== {3'b100, 2'(t)}) begin n_bad++; $display("FAIL lock_retry%0d: got %b want %b", t, obs, {3'b100, 2'(t)}); end
      end
    end
    n_cmp++; if (obs !== 5'b01111) begin n_bad++; $display("FAIL lock_enter: got %b want 01111", obs); end
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, i[0], 0);
      n_cmp++; if (obs !== 5'b01111) begin n_bad++; $display("FAIL lock_hold%0d: got %b want 01111", i, obs); end
    end
    tick(0, 1, 1, 1);
    n_cmp++; if (obs !== 5'b01111) begin n_bad++; $display("FAIL lock_clear_ignored: got %b want 01111", obs); end
    tick(0, 0, 1, 1);
    n_cmp++; if (obs !== 5'b00000) begin n_bad++; $display("FAIL lock_clear: got %b want 00000", obs); end
    tick(0, 0, 1, 0);
    n_cmp++; if (obs !== 5'b10000) begin n_bad++; $display("FAIL lock_restart: got %b want 10000", obs); end
  endtask

  task automatic test_fault_in_cooldown();
    tick(0, 1, 1, 0); tick(0, 1, 1, 0); tick(0, 0, 1, 0);
    n_cmp++; if (obs !== 5'b01001) begin n_bad++; $display("FAIL fic_cool: got %b want 01001", obs); end
    tick(0, 0, 1, 0); tick(0, 1, 1, 0);
    n_cmp++; if (obs !== 5'b01001) begin n_bad++; $display("FAIL fic_rehold: got %b want 01001", obs); end
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 1, 0);
      n_cmp++; if (obs !== 5'b01010) begin n_bad++; $display("FAIL fic_cool%0d: got %b want 01010", i, obs); end
    end
    tick(0, 0, 1, 0);
    n_cmp++; if (obs !== 5'b10010) begin n_bad++; $display("FAIL fic_restart: got %b want 10010", obs); end
  endtask

  task automatic test_simultaneous();
    tick(0, 1, 1, 0); tick(0, 1, 0, 0);
    n_cmp++; if (obs !== 5'b01010) begin n_bad++; $display("FAIL simul_hold: got %b want 01010", obs); end
    tick(0, 0, 0, 0);
    n_cmp++; if (obs !== 5'b01011) begin n_bad++; $display("FAIL simul_cool: got %b want 01011", obs); end
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
    n_cmp++; if (obs !== 5'b00011) begin n_bad++; $display("FAIL simul_idle: got %b want 00011", obs); end
    tick(0, 0, 0, 0);
    n_cmp++; if (obs !== 5'b00000) begin n_bad++; $display("FAIL simul_rc_clear: got %b want 00000", obs); end
  endtask

  task automatic test_reset_mid_cooldown();
    tick(0, 0, 1, 0); tick(0, 1, 1, 0); tick(0, 1, 1, 0); tick(0, 0, 1, 0); tick(0, 0, 1, 0);
    n_cmp++; if (obs !== 5'b01001) begin n_bad++; $display("FAIL rstmid_pre: got %b want 01001", obs); end
    tick(1, 0, 1, 0);
    n_cmp++; if (obs !== 5'b00000) begin n_bad++; $display("FAIL rstmid: got %b want 00000", obs); end
    tick(0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic f = 0, e = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) f = ~f;
      if ($urandom_range(0, 39) == 0) e = ~e;
      tick($urandom_range(0, 399) == 0, f ^ ($urandom_range(0, 29) == 0), e, $urandom_range(0, 7) == 0);
      n_cmp++;
      if (obs !== model_out()) begin n_bad++; $display("FAIL random@%0d: got %b want %b", i, obs, model_out()); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_glitch();
    test_single_trip();
    test_lockout();
    test_fault_in_cooldown();
    test_simultaneous();
    test_reset_mid_cooldown();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
